// File: rtl/acl2_spi_responder.sv
// SPI mode-0 responder modelling the ACL2 (ADXL362-style) accelerometer register interface.
// Optional interrupt output is enabled by defining ACL2_RESP_INT_EN.
module acl2_spi_responder #(
  parameter logic [7:0] DEVID_AD = 8'hAD,
  parameter logic [7:0] PARTID   = 8'hF2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;

  logic        cs_meta_q, cs_sync_q, cs_prev_q;
  logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic        mosi_meta_q, mosi_sync_q;
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [7:0]  power_q, power_d, filter_q, filter_d;
  logic [11:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [11:0] px_q, px_d, py_q, py_d, pz_q, pz_d;
  logic        pend_q, pend_d, dr_q, dr_d;
`ifdef ACL2_RESP_INT_EN
  logic [7:0]  intmap_q, intmap_d;
  logic        int1_q;
`endif

  logic       cs_fall, cs_rise, sclk_rise, sclk_fall, measure;
  logic       dr_set, dr_clr, soft_rst;
  logic [7:0] rx_byte, rd_data;

  assign cs_fall   = cs_prev_q & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q & cs_sync_q;
  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
  assign rx_byte   = {rx_q[6:0], mosi_sync_q};
  assign measure   = (power_q[1:0] == 2'b10);

  assign busy = ~cs_sync_q;
  assign miso = tx_q[7] & ~cs_sync_q;

  always_comb begin
    rd_data = 8'h00;
    case (addr_q)
      8'h00:   rd_data = DEVID_AD;
      8'h01:   rd_data = 8'h1D;
      8'h02:   rd_data = PARTID;
      8'h03:   rd_data = 8'h01;
      8'h0B:   rd_data = {7'b0, dr_q};
      8'h0E:   rd_data = x_q[7:0];
      8'h0F:   rd_data = {{4{x_q[11]}}, x_q[11:8]};
      8'h10:   rd_data = y_q[7:0];
      8'h11:   rd_data = {{4{y_q[11]}}, y_q[11:8]};
      8'h12:   rd_data = z_q[7:0];
      8'h13:   rd_data = {{4{z_q[11]}}, z_q[11:8]};
`ifdef ACL2_RESP_INT_EN
      8'h2A:   rd_data = intmap_q;
`endif
      8'h2C:   rd_data = filter_q;
      8'h2D:   rd_data = power_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    power_d   = power_q;
    filter_d  = filter_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    px_d      = px_q;
    py_d      = py_q;
    pz_d      = pz_q;
    pend_d    = pend_q;
    dr_d      = dr_q;
    dr_set    = 1'b0;
    dr_clr    = 1'b0;
    soft_rst  = 1'b0;
`ifdef ACL2_RESP_INT_EN
    intmap_d  = intmap_q;
`endif

    if (cs_rise) begin
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
    end else if (state_q == StIdle) begin
      if (cs_fall) begin
        state_d   = StCmd;
        bit_cnt_d = 3'd0;
        rx_d      = 8'h00;
        tx_d      = 8'h00;
      end
    end else if (sclk_rise) begin
      rx_d      = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          StCmd: begin
            if (rx_byte == 8'h0A) begin
              state_d = StAddr;
              wr_d    = 1'b1;
            end else if (rx_byte == 8'h0B) begin
              state_d = StAddr;
              wr_d    = 1'b0;
            end else begin
              state_d = StIgnore;
            end
          end
          StAddr: begin
            addr_d  = rx_byte;
            state_d = StData;
          end
          StData: begin
            if (wr_q) begin
              case (addr_q)
`ifdef ACL2_RESP_INT_EN
                8'h2A:   intmap_d = rx_byte;
`endif
                8'h2C:   filter_d = rx_byte;
                8'h2D:   power_d  = rx_byte;
                8'h1F:   soft_rst = (rx_byte == 8'h52);
                default: ;
              endcase
              addr_d = addr_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end else if (sclk_fall && state_q == StData && !wr_q) begin
      // A byte boundary reloads the shifter; MSB appears for the master's next rising edge.
      if (bit_cnt_q == 3'd0) begin
        tx_d   = rd_data;
        addr_d = addr_q + 8'd1;
        dr_clr = (addr_q == 8'h13);
      end else begin
        tx_d = {tx_q[6:0], 1'b0};
      end
    end

    if (sample_valid && measure) begin
      if (!busy) begin
        x_d    = sample_x;
        y_d    = sample_y;
        z_d    = sample_z;
        pend_d = 1'b0;
        dr_set = 1'b1;
      end else begin
        px_d   = sample_x;
        py_d   = sample_y;
        pz_d   = sample_z;
        pend_d = 1'b1;
      end
    end else if (pend_q && cs_sync_q) begin
      x_d    = px_q;
      y_d    = py_q;
      z_d    = pz_q;
      pend_d = 1'b0;
      dr_set = 1'b1;
    end

    if (dr_set) begin
      dr_d = 1'b1;
    end else if (dr_clr) begin
      dr_d = 1'b0;
    end

    if (soft_rst) begin
      power_d  = 8'h00;
      filter_d = 8'h13;
      x_d      = 12'h000;
      y_d      = 12'h000;
      z_d      = 12'h000;
      pend_d   = 1'b0;
      dr_d     = 1'b0;
`ifdef ACL2_RESP_INT_EN
      intmap_d = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= 8'h00;
      wr_q        <= 1'b0;
      power_q     <= 8'h00;
      filter_q    <= 8'h13;
      x_q         <= 12'h000;
      y_q         <= 12'h000;
      z_q         <= 12'h000;
      px_q        <= 12'h000;
      py_q        <= 12'h000;
      pz_q        <= 12'h000;
      pend_q      <= 1'b0;
      dr_q        <= 1'b0;
    end else begin
      cs_meta_q   <= cs;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sclk_meta_q <= sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      power_q     <= power_d;
      filter_q    <= filter_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pz_q        <= pz_d;
      pend_q      <= pend_d;
      dr_q        <= dr_d;
    end
  end

`ifdef ACL2_RESP_INT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      intmap_q <= 8'h00;
      int1_q   <= 1'b0;
    end else begin
      intmap_q <= intmap_d;
      int1_q   <= dr_q & intmap_q[0];
    end
  end
  assign int1 = int1_q;
`else
  assign int1 = 1'b0;
`endif

endmodule
